// File: rtl/sync_req_arbiter.sv
// Round-robin arbiter for NUM_REQ asynchronous request lines sharing one resource.
// Request edges are synchronized, latched as pending, and served one at a time with a timeout.
module sync_req_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int TIMEOUT = 16,
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_REQ-1:0] async_req,
   input  logic               done,
   output logic [NUM_REQ-1:0] grant,
   output logic [ID_W-1:0]    grant_id,
   output logic               busy,
   output logic [NUM_REQ-1:0] pending,
   output logic [NUM_REQ-1:0] overrun,
   output logic               timeout
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic [NUM_REQ-1:0]  s1_q, s2_q, s3_q;
   logic [NUM_REQ-1:0]  pending_q, pending_d;
   logic [NUM_REQ-1:0]  overrun_q, overrun_d;
   logic [ID_W-1:0]     grant_id_q, grant_id_d;
   logic [ID_W-1:0]     last_id_q, last_id_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
   logic [1:0]          warm_q, warm_d;

   logic [NUM_REQ-1:0]  rise;
   logic [NUM_REQ-1:0]  clr;
   logic                release_now;
   logic                armed;
   logic                win_found;
   logic [ID_W-1:0]     win_id;

   // Edges are masked until s3 has been loaded once after reset, so lines that
   // were already high when reset released are not mistaken for new requests.
   assign armed  = (warm_q == 2'd3);
   assign warm_d = armed ? warm_q : warm_q + 2'd1;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
         assign rise[gi]      = armed & s2_q[gi] & ~s3_q[gi];
         assign clr[gi]       = release_now & (grant_id_q == ID_W'(gi));
         // A new edge beats a simultaneous clear; only an edge onto an uncleared pending bit is lost.
         assign pending_d[gi] = (pending_q[gi] & ~clr[gi]) | rise[gi];
         assign overrun_d[gi] = overrun_q[gi] | (rise[gi] & pending_q[gi] & ~clr[gi]);
         assign grant[gi]     = (state_q == GRANT) & (grant_id_q == ID_W'(gi));
      end
   endgenerate

   always_comb begin
      int idx;
      idx       = 0;
      win_found = 1'b0;
      win_id    = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = int'(last_id_q) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!win_found && pending_q[idx]) begin
            win_found = 1'b1;
            win_id    = ID_W'(idx);
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      last_id_d   = last_id_q;
      cnt_d       = cnt_q;
      timeout_d   = 1'b0;
      release_now = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d    = GRANT;
               grant_id_d = win_id;
               cnt_d      = 8'd0;
            end
         end
         GRANT: begin
            if (done || (cnt_q == CNT_MAX)) begin
               release_now = 1'b1;
               state_d     = IDLE;
               last_id_d   = grant_id_q;
               grant_id_d  = '0;
               cnt_d       = 8'd0;
               timeout_d   = ~done;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q       <= '0;
         s2_q       <= '0;
         s3_q       <= '0;
         warm_q     <= 2'd0;
         pending_q  <= '0;
         overrun_q  <= '0;
         state_q    <= IDLE;
         grant_id_q <= '0;
         last_id_q  <= ID_W'(NUM_REQ - 1);
         cnt_q      <= 8'd0;
         timeout_q  <= 1'b0;
      end else begin
         s1_q       <= async_req;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         warm_q     <= warm_d;
         pending_q  <= pending_d;
         overrun_q  <= overrun_d;
         state_q    <= state_d;
         grant_id_q <= grant_id_d;
         last_id_q  <= last_id_d;
         cnt_q      <= cnt_d;
         timeout_q  <= timeout_d;
      end
   end

   assign grant_id = grant_id_q;
   assign busy     = (state_q == GRANT);
   assign pending  = pending_q;
   assign overrun  = overrun_q;
   assign timeout  = timeout_q;

endmodule

// File: tb/tb_sync_req_arbiter.sv
// Directed bench for sync_req_arbiter: cycle table for basic arbitration plus
// hand-written sequences for fairness, timeout, overrun, set-vs-clear and reset.
module tb_sync_req_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] async_req = 4'b0;
   logic       done = 1'b0;
   logic [3:0] grant;
   logic [1:0] grant_id;
   logic       busy;
   logic [3:0] pending;
   logic [3:0] overrun;
   logic       timeout;

   int n_cmp = 0;
   int n_bad = 0;

   sync_req_arbiter #(.NUM_REQ(4), .TIMEOUT(16)) dut (
      .clk      (clk),
      .rst      (rst),
      .async_req(async_req),
      .done     (done),
      .grant    (grant),
      .grant_id (grant_id),
      .busy     (busy),
      .pending  (pending),
      .overrun  (overrun),
      .timeout  (timeout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] req;
      logic       dn;
      logic [3:0] exp_grant;
      logic [1:0] exp_id;
      logic       exp_busy;
      logic [3:0] exp_pend;
   } vec_t;

   vec_t tbl [15];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   task automatic do_reset(input logic [3:0] hold_req);
      rst = 1'b1;
      done = 1'b0;
      async_req = hold_req;
      tick();
      tick();
      rst = 1'b0;
      repeat (5) tick();
   endtask

   task automatic wait_busy(input int max_cyc, input string name);
      int n;
      n = 0;
      while (!busy && n < max_cyc) begin
         tick();
         n++;
      end
      check(name, 32'(busy), 32'd1);
   endtask

   task automatic serve(input logic [1:0] exp_id, input int hold, input string name);
      wait_busy(20, {name, "_busy"});
      check({name, "_id"}, 32'(grant_id), 32'(exp_id));
      check({name, "_grant"}, 32'(grant), 32'(4'b0001 << exp_id));
      repeat (hold - 1) tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      check({name, "_release"}, 32'(busy), 32'd0);
   endtask

   initial begin
      int busy_cnt;
      int to_cnt;

      // Row k inputs are sampled at edge k; outputs checked just after it.
      tbl[0]  = '{4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
      tbl[1]  = '{4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
      tbl[2]  = '{4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0100};
      tbl[3]  = '{4'b0100, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0100};
      tbl[4]  = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
      tbl[5]  = '{4'b0100, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
      tbl[6]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
      tbl[7]  = '{4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
      tbl[8]  = '{4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
      tbl[9]  = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b1001};
      tbl[10] = '{4'b0000, 1'b0, 4'b1000, 2'd3, 1'b1, 4'b1001};
      tbl[11] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0001};
      tbl[12] = '{4'b0000, 1'b0, 4'b0001, 2'd0, 1'b1, 4'b0001};
      tbl[13] = '{4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
      tbl[14] = '{4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};

      // Reset state
      tick();
      check("rst_grant", 32'(grant), 32'd0);
      check("rst_id", 32'(grant_id), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_pending", 32'(pending), 32'd0);
      check("rst_overrun", 32'(overrun), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);

      // Table: single request latency, done-in-idle, round-robin from last_id
      do_reset(4'b0000);
      for (int i = 0; i < 15; i++) begin
         async_req = tbl[i].req;
         done      = tbl[i].dn;
         tick();
         check($sformatf("row%0d_grant", i), 32'(grant), 32'(tbl[i].exp_grant));
         check($sformatf("row%0d_id", i), 32'(grant_id), 32'(tbl[i].exp_id));
         check($sformatf("row%0d_busy", i), 32'(busy), 32'(tbl[i].exp_busy));
         check($sformatf("row%0d_pend", i), 32'(pending), 32'(tbl[i].exp_pend));
      end
      done = 1'b0;

      // Fairness: all rise together, order 0,1,2,3 twice
      do_reset(4'b0000);
      async_req = 4'b1111;
      tick();
      tick();
      async_req = 4'b0000;
      for (int r = 0; r < 4; r++) serve(2'(r), 2, $sformatf("fair1_%0d", r));
      repeat (3) tick();
      async_req = 4'b1111;
      tick();
      tick();
      async_req = 4'b0000;
      for (int r = 0; r < 4; r++) serve(2'(r), 2, $sformatf("fair2_%0d", r));

      // Timeout: request 1 with no done
      do_reset(4'b0000);
      async_req = 4'b0010;
      tick();
      tick();
      async_req = 4'b0000;
      wait_busy(20, "to_busy");
      busy_cnt = 1;
      to_cnt = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (busy) busy_cnt++;
         if (timeout) to_cnt++;
      end
      check("to_busy_cycles", 32'(busy_cnt), 32'd16);
      check("to_pulses", 32'(to_cnt), 32'd1);
      check("to_pending", 32'(pending), 32'd0);
      check("to_busy_end", 32'(busy), 32'd0);

      // Overrun: requester 3 pulses twice while 0 is granted
      do_reset(4'b0000);
      async_req = 4'b0001;
      tick();
      tick();
      async_req = 4'b0000;
      wait_busy(20, "ovr_busy0");
      check("ovr_grant0", 32'(grant), 32'h1);
      for (int p = 0; p < 2; p++) begin
         async_req = 4'b1000;
         tick();
         tick();
         async_req = 4'b0000;
         repeat (3) tick();
      end
      check("ovr_flag", 32'(overrun), 32'h8);
      check("ovr_still_grant0", 32'(grant), 32'h1);
      done = 1'b1;
      tick();
      done = 1'b0;
      serve(2'd3, 2, "ovr_serve3");
      busy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy) busy_cnt++;
      end
      check("ovr_served_once", 32'(busy_cnt), 32'd0);
      check("ovr_pending", 32'(pending), 32'd0);
      check("ovr_sticky", 32'(overrun), 32'h8);

      // Set-vs-clear: rise[2] lands on the done edge for grant 2
      do_reset(4'b0000);
      async_req = 4'b0100;
      tick();
      tick();
      async_req = 4'b0000;
      wait_busy(20, "svc_busy");
      check("svc_id", 32'(grant_id), 32'd2);
      repeat (3) tick();
      async_req = 4'b0100;
      tick();
      tick();
      done = 1'b1;
      tick();
      done = 1'b0;
      async_req = 4'b0000;
      check("svc_released", 32'(busy), 32'd0);
      check("svc_pending", 32'(pending), 32'h4);
      check("svc_overrun", 32'(overrun), 32'h0);
      tick();
      check("svc_regrant", 32'(grant), 32'h4);

      // Inputs high across reset produce no edge until they fall and rise again
      do_reset(4'b0001);
      repeat (4) tick();
      check("hold_no_pending", 32'(pending), 32'd0);
      check("hold_no_busy", 32'(busy), 32'd0);
      async_req = 4'b0000;
      repeat (4) tick();
      async_req = 4'b0001;
      repeat (3) tick();
      check("hold_rerise_pend", 32'(pending), 32'h1);
      async_req = 4'b0000;

      // Reset mid-grant drops everything immediately
      do_reset(4'b0000);
      async_req = 4'b0010;
      tick();
      tick();
      async_req = 4'b0000;
      wait_busy(20, "mid_busy");
      check("mid_grant_before", 32'(grant), 32'h2);
      #2;
      rst = 1'b1;
      #1;
      check("mid_grant", 32'(grant), 32'd0);
      check("mid_id", 32'(grant_id), 32'd0);
      check("mid_busy", 32'(busy), 32'd0);
      check("mid_pending", 32'(pending), 32'd0);
      check("mid_timeout", 32'(timeout), 32'd0);
      tick();
      rst = 1'b0;
      busy_cnt = 0;
      to_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (busy) busy_cnt++;
         if (timeout) to_cnt++;
      end
      check("mid_after_busy", 32'(busy_cnt), 32'd0);
      check("mid_after_timeout", 32'(to_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/sync_req_arbiter.md
SYNC_REQ_ARBITER -- requirements
Module: sync_req_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of asynchronous requesters (legal 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum grant cycles before forced release (legal 2..255).
REQ-003 SHALL derive ID_W = clog2(NUM_REQ).
REQ-004 SHALL have port clk  input  1  single system clock; all state on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port async_req  input  NUM_REQ  unsynchronized request lines; rising edge = one request.
REQ-007 SHALL have port done  input  1  synchronous pulse from the shared resource; current grant finished.
REQ-008 SHALL have port grant  output  NUM_REQ  one-hot grant to the shared resource; all zero when idle.
REQ-009 SHALL have port grant_id  output  ID_W  index of granted requester; 0 when idle.
REQ-010 SHALL have port busy  output  1  high while in GRANT state.
REQ-011 SHALL have port pending  output  NUM_REQ  latched, not-yet-served requests.
REQ-012 SHALL have port overrun  output  NUM_REQ  sticky: request edge lost because pending was already set.
REQ-013 SHALL have port timeout  output  1  one-cycle pulse on forced release.

Function
REQ-014 Each async_req bit SHALL pass through its own two-flop synchronizer (s1, s2), plus a third flop s3 for edge detection.
REQ-015 A request edge SHALL be rise[i] = s2[i] & ~s3[i]; level-high inputs SHALL produce exactly one edge.
REQ-016 Rise sampled into s1 at edge N SHALL set pending[i] at edge N+2.
REQ-017 FSM SHALL have two states: IDLE, GRANT.
REQ-018 IDLE: if any pending bit set, SHALL select winner by round-robin and enter GRANT on the next edge; else remain IDLE.
REQ-019 Round-robin SHALL search from last_id+1 upward, wrapping at NUM_REQ-1 to 0; first pending bit found wins.
REQ-020 On entering GRANT, grant SHALL be one-hot at winner, grant_id = winner, busy = 1, timeout counter loaded with 0.
REQ-021 Latency SHALL be: rise sampled at edge N -> grant high after edge N+3 when IDLE and no other pending.
REQ-022 GRANT: counter SHALL increment each cycle; done = 1 SHALL clear pending[grant_id], set last_id = grant_id, return to IDLE on the same edge.
REQ-023 GRANT: if counter reaches TIMEOUT-1 without done, SHALL release as REQ-022 and pulse timeout for exactly one cycle.
REQ-024 done while in IDLE SHALL be ignored.
REQ-025 Grant SHALL hold at least one cycle; no back-to-back re-grant without one IDLE cycle between grants.
REQ-026 Simultaneous rise[i] and clear of pending[i]: set SHALL win, pending[i] stays 1, overrun[i] unchanged.
REQ-027 rise[i] while pending[i] = 1 and not being cleared SHALL set overrun[i]; overrun cleared only by reset.
REQ-028 Arbitration SHALL be starvation-free: any pending requester granted within NUM_REQ grants.

Reset
REQ-029 rst high SHALL asynchronously clear s1/s2/s3, pending, overrun, counter, timeout; grant = 0, grant_id = 0, busy = 0, state = IDLE, last_id = NUM_REQ-1.
REQ-030 Reset asserted mid-grant SHALL drop grant immediately, with no done or timeout reported.
REQ-031 After rst deasserts, inputs already high SHALL NOT produce edges until they fall and rise again.

Verification
REQ-032 Single request: async_req = 4'b0100 held -> grant = 4'b0100, grant_id = 2 three edges after first sampling; done pulse -> grant = 0, pending = 0.
REQ-033 Fairness: all four requests rise together, done after 2 cycles each -> grant order 0,1,2,3; repeat -> 0,1,2,3.
REQ-034 Timeout: TIMEOUT = 16, request 1, no done -> grant high 16 cycles, timeout pulses once, pending[1] = 0, busy = 0.
REQ-035 Overrun: request 3 pulses twice while requester 0 is granted -> overrun = 4'b1000, requester 3 served once.
REQ-036 Set-vs-clear: requester 2 re-rises so rise[2] coincides with done for grant 2 -> pending[2] = 1, overrun[2] = 0, requester 2 granted again.
REQ-037 Reset mid-grant: rst pulsed while grant = 4'b0010 -> grant = 0 asynchronously, all outputs at reset values, no timeout pulse.
